// File: rtl/image_scatter_write_pkg.sv
// Shared definitions for the image scatter writer: config register map and FSM states.
package image_scatter_write_pkg;

    // Config register addresses
    localparam int unsigned CFG_IW_WIDTH  = 8;
    localparam int unsigned CFG_IW_HEIGHT = 9;
    localparam int unsigned CFG_IW_DEPTH  = 10;
    localparam int unsigned CFG_IW_BASE   = 11;
    localparam int unsigned CFG_IW_STRIDE = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/image_scatter_agu.sv
// Address generator for the scatter writer.
// Walks depth (innermost), column, then row; rows rotate across banks, and
// row_base advances by one image width each time the bank rotor wraps.
// Ports: load/init_base restart a job, step advances one beat, width/height/
// depth are zero-indexed counts, stride separates depth planes.
// addr/bank describe the current beat; last_c flags the final beat of the job.
module image_scatter_agu #(
    parameter int unsigned MEM_AWIDTH = 16,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned DIM_WIDTH  = 16,
    parameter int unsigned BANK_W     = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [MEM_AWIDTH-1:0] init_base,
    input  logic                  step,
    input  logic [DIM_WIDTH-1:0]  width,
    input  logic [DIM_WIDTH-1:0]  height,
    input  logic [DIM_WIDTH-1:0]  depth,
    input  logic [MEM_AWIDTH-1:0] stride,
    output logic [MEM_AWIDTH-1:0] addr,
    output logic [BANK_W-1:0]     bank,
    output logic                  last_c
);

    logic [DIM_WIDTH-1:0]  d_cnt;
    logic [DIM_WIDTH-1:0]  c_cnt;
    logic [DIM_WIDTH-1:0]  r_cnt;
    logic [MEM_AWIDTH-1:0] row_base;
    logic [MEM_AWIDTH-1:0] row_base_adv;
    logic                  bank_wrap;
    logic [BANK_W-1:0]     bank_nxt;

    assign bank_wrap    = (bank == BANK_W'(NB_BANKS - 1));
    assign bank_nxt     = bank_wrap ? '0 : bank + BANK_W'(1);
    assign row_base_adv = row_base + MEM_AWIDTH'(width) + MEM_AWIDTH'(1);
    assign last_c       = (d_cnt == depth) && (c_cnt == width) && (r_cnt == height);

    // Incremental address walk; acc doubles as the current beat address
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_cnt    <= '0;
            c_cnt    <= '0;
            r_cnt    <= '0;
            bank     <= '0;
            row_base <= '0;
            addr     <= '0;
        end else if (load) begin
            d_cnt    <= '0;
            c_cnt    <= '0;
            r_cnt    <= '0;
            bank     <= '0;
            row_base <= init_base;
            addr     <= init_base;
        end else if (step) begin
            if (d_cnt != depth) begin
                d_cnt <= d_cnt + DIM_WIDTH'(1);
                addr  <= addr + stride;
            end else begin
                d_cnt <= '0;
                if (c_cnt != width) begin
                    c_cnt <= c_cnt + DIM_WIDTH'(1);
                    addr  <= row_base + MEM_AWIDTH'(c_cnt) + MEM_AWIDTH'(1);
                end else begin
                    c_cnt <= '0;
                    r_cnt <= r_cnt + DIM_WIDTH'(1);
                    bank  <= bank_nxt;
                    if (bank_wrap) begin
                        row_base <= row_base_adv;
                        addr     <= row_base_adv;
                    end else begin
                        addr     <= row_base;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/image_scatter_write.sv
// Multi-bank image writer: scatters the image stream into NB_BANKS banks,
// rows interleaved across banks, depth words placed in stride-separated planes.
// Ports: cfg_* stage job geometry, next launches a job from the staged set,
// str_img_* is the input stream, wr_* is the shared registered bank write port,
// busy covers the job, done pulses once after the last write.
module image_scatter_write
    import image_scatter_write_pkg::*;
#(
    parameter int unsigned CFG_DWIDTH    = 32,
    parameter int unsigned CFG_AWIDTH    = 5,
    parameter int unsigned STR_IMG_WIDTH = 64,
    parameter int unsigned MEM_AWIDTH    = 16,
    parameter int unsigned NB_BANKS      = 4,
    parameter int unsigned DIM_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [CFG_DWIDTH-1:0]    cfg_data,
    input  logic [CFG_AWIDTH-1:0]    cfg_addr,
    input  logic                     cfg_valid,
    input  logic                     next,
    input  logic [STR_IMG_WIDTH-1:0] str_img_bus,
    input  logic                     str_img_val,
    output logic                     str_img_rdy,
    output logic [NB_BANKS-1:0]      wr_val,
    output logic [MEM_AWIDTH-1:0]    wr_addr,
    output logic [STR_IMG_WIDTH-1:0] wr_data,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned BANK_W = (NB_BANKS > 1) ? $clog2(NB_BANKS) : 1;

    logic [DIM_WIDTH-1:0]  stg_width, stg_height, stg_depth;
    logic [MEM_AWIDTH-1:0] stg_base, stg_stride;
    logic [DIM_WIDTH-1:0]  act_width, act_height, act_depth;
    logic [MEM_AWIDTH-1:0] act_stride;

    state_t                state, state_nxt;
    logic                  load;
    logic                  beat;
    logic                  rdy_d, busy_d, done_d;
    logic [MEM_AWIDTH-1:0] agu_addr;
    logic [BANK_W-1:0]     agu_bank;
    logic                  agu_last_c;
    logic                  unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_data;
    assign beat            = str_img_val & str_img_rdy;

    // Staging set: written at any time, only ever consumed by next job launch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stg_width  <= '0;
            stg_height <= '0;
            stg_depth  <= '0;
            stg_base   <= '0;
            stg_stride <= '0;
        end else if (cfg_valid) begin
            case (cfg_addr)
                CFG_AWIDTH'(CFG_IW_WIDTH):  stg_width  <= cfg_data[DIM_WIDTH-1:0];
                CFG_AWIDTH'(CFG_IW_HEIGHT): stg_height <= cfg_data[DIM_WIDTH-1:0];
                CFG_AWIDTH'(CFG_IW_DEPTH):  stg_depth  <= cfg_data[DIM_WIDTH-1:0];
                CFG_AWIDTH'(CFG_IW_BASE):   stg_base   <= cfg_data[MEM_AWIDTH-1:0];
                CFG_AWIDTH'(CFG_IW_STRIDE): stg_stride <= cfg_data[MEM_AWIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Active set: captured from staging at launch, frozen during the job
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_width  <= '0;
            act_height <= '0;
            act_depth  <= '0;
            act_stride <= '0;
        end else if (load) begin
            act_width  <= stg_width;
            act_height <= stg_height;
            act_depth  <= stg_depth;
            act_stride <= stg_stride;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // FSM next state and next output values
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (next) begin
                    state_nxt = ST_RUN;
                    load      = 1'b1;
                end
            end
            ST_RUN:  if (beat && agu_last_c) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        rdy_d  = (state_nxt == ST_RUN);
        // done trails the final write by one cycle, so busy is stretched over it
        busy_d = (state_nxt != ST_IDLE) || (state == ST_DONE);
        done_d = (state == ST_DONE);
    end

    // Registered control and write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            str_img_rdy <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            wr_val      <= '0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            str_img_rdy <= rdy_d;
            busy        <= busy_d;
            done        <= done_d;
            if (beat) begin
                wr_val  <= NB_BANKS'(1) << agu_bank;
                wr_addr <= agu_addr;
                wr_data <= str_img_bus;
            end else begin
                wr_val  <= '0;
            end
        end
    end

    image_scatter_agu #(
        .MEM_AWIDTH (MEM_AWIDTH),
        .NB_BANKS   (NB_BANKS),
        .DIM_WIDTH  (DIM_WIDTH),
        .BANK_W     (BANK_W)
    ) u_agu (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .init_base (stg_base),
        .step      (beat),
        .width     (act_width),
        .height    (act_height),
        .depth     (act_depth),
        .stride    (act_stride),
        .addr      (agu_addr),
        .bank      (agu_bank),
        .last_c    (agu_last_c)
    );

endmodule
